display_arbiter: RTL and testbench



---
 rtl/display_arbiter_if.sv | 12 +
 rtl/display_arbiter.sv | 93 +++++++++
 tb/tb_display_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/display_arbiter_if.sv
// display_arbiter_if: requester-side and display-side signals of the shared 7-segment display arbiter.
interface display_arbiter_if;
  logic [3:0]   Request_i;
  logic [127:0] Data_i;
  logic [31:0]  DecimalPoints_i;
  logic [3:0]   Grant_o;
  logic [31:0]  Data_o;
  logic [7:0]   DecimalPoints_o;
  logic         Busy_o;
  modport master (output Request_i, Data_i, DecimalPoints_i, input Grant_o, Data_o, DecimalPoints_o, Busy_o);
  modport slave (input Request_i, Data_i, DecimalPoints_i, output Grant_o, Data_o, DecimalPoints_o, Busy_o);
endinterface

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin sharing of one 8-digit 7-segment display between four sources with a minimum hold time.
// Define DISPLAY_ARBITER_PRIORITY_EN to let requester 0 pre-empt any other owner.
module display_arbiter #(
  parameter int unsigned CLOCK_HZ  = 10_000_000,
  parameter int unsigned HOLD_US   = 500_000,
  parameter logic [31:0] IDLE_DATA = 32'h0000_0000,
  parameter logic [7:0]  IDLE_DP   = 8'h00
) (
  input logic Clock,
  input logic Reset,
  display_arbiter_if.slave bus
);
  localparam int unsigned HOLD_RAW    = CLOCK_HZ / 1_000_000 * HOLD_US;
  localparam int unsigned HOLD_CYCLES = HOLD_RAW < 1 ? 1 : HOLD_RAW;
  localparam logic [31:0] HOLD_LOAD   = 32'(HOLD_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, HOLD, LINGER} state_t;
  state_t      state;
  logic [3:0]  grant;
  logic [31:0] data, cnt;
  logic [7:0]  dp;
  logic        busy;
  logic [1:0]  last, win, idx, nwin;
  logic        hit, expired, owner_req, pending, urgent, regrant, to_linger, to_idle, load, blank;
  // last doubles as the owner index while in HOLD; searching last+4 puts it at lowest priority
  always_comb begin
    win = last;
    hit = 1'b0;
    idx = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (bus.Request_i[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    expired   = cnt == '0;
    owner_req = bus.Request_i[last];
    pending   = |(bus.Request_i & ~grant);
`ifdef DISPLAY_ARBITER_PRIORITY_EN
    urgent    = bus.Request_i[0] && ((state == HOLD && last != 2'd0) || state == LINGER);
`else
    urgent    = 1'b0;
`endif
    regrant   = state == IDLE ? hit :
                state == HOLD ? (owner_req ? expired && pending : expired && hit) :
                state == LINGER ? expired && hit : 1'b0;
    to_linger = state == HOLD && !owner_req && !expired;
    to_idle   = (state == HOLD && !owner_req && expired && !hit) || (state == LINGER && expired && !hit);
    load      = state == HOLD && !to_linger && !to_idle;
    blank     = state == IDLE || to_idle;
    nwin      = urgent ? 2'd0 : win;
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      grant <= '0;
      data  <= IDLE_DATA;
      dp    <= IDLE_DP;
      busy  <= 1'b0;
      last  <= 2'd3;
      cnt   <= '0;
    end else begin
      cnt <= expired ? cnt : cnt - 1'b1;
      if (load) begin
        data <= bus.Data_i[{last, 5'b0} +: 32];
        dp   <= bus.DecimalPoints_i[{last, 3'b0} +: 8];
      end else if (blank) begin
        data <= IDLE_DATA;
        dp   <= IDLE_DP;
      end
      if (urgent || regrant) begin
        state <= HOLD;
        grant <= 4'b0001 << nwin;
        last  <= nwin;
        cnt   <= HOLD_LOAD;
        busy  <= 1'b1;
      end else if (to_linger) begin
        state <= LINGER;
        grant <= '0;
      end else if (to_idle) begin
        state <= IDLE;
        grant <= '0;
        busy  <= 1'b0;
      end
    end
  end
  assign bus.Grant_o         = grant;
  assign bus.Data_o          = data;
  assign bus.DecimalPoints_o = dp;
  assign bus.Busy_o          = busy;
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed checks of grant sequencing, hold time, linger and idle behaviour.
module tb_display_arbiter;
  localparam logic [31:0] IDLE_D = 32'hEEEE_EEEE;
  localparam logic [7:0]  IDLE_P = 8'hA5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] dv [4];
  logic [7:0]  pv [4];
  display_arbiter_if bus ();
  display_arbiter #(.CLOCK_HZ(1_000_000), .HOLD_US(4), .IDLE_DATA(IDLE_D), .IDLE_DP(IDLE_P)) dut (
    .Clock(clk),
    .Reset(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.Data_i = {dv[3], dv[2], dv[1], dv[0]};
  assign bus.DecimalPoints_i = {pv[3], pv[2], pv[1], pv[0]};
  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset(logic [3:0] req);
    rst_n = 1'b0;
    bus.Request_i = req;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.Request_i = 4'($urandom);
    for (int n = 0; n < 4; n++) begin
      dv[n] = $urandom;
      pv[n] = 8'($urandom);
    end
    tick(2);
    checks++; if (bus.Grant_o !== 4'b0) begin errors++; $display("FAIL reset_grant got %b want 0000", bus.Grant_o); end
    checks++; if (bus.Data_o !== IDLE_D) begin errors++; $display("FAIL reset_data got %h want %h", bus.Data_o, IDLE_D); end
    checks++; if (bus.DecimalPoints_o !== IDLE_P) begin errors++; $display("FAIL reset_dp got %h want %h", bus.DecimalPoints_o, IDLE_P); end
    checks++; if (bus.Busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.Busy_o); end
    bus.Request_i = '0;
    rst_n = 1'b1;
    tick(3);
    checks++; if (bus.Grant_o !== 4'b0) begin errors++; $display("FAIL idle_grant got %b want 0000", bus.Grant_o); end
    checks++; if (bus.Busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.Busy_o); end
    checks++; if (bus.Data_o !== IDLE_D) begin errors++; $display("FAIL idle_data got %h want %h", bus.Data_o, IDLE_D); end
  endtask
  task automatic test_single();
    dv[2] = 32'h0000_1234;
    pv[2] = 8'h42;
    bus.Request_i = 4'b0100;
    tick();
    checks++; if (bus.Grant_o !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", bus.Grant_o); end
    checks++; if (bus.Busy_o !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", bus.Busy_o); end
    checks++; if (bus.Data_o !== IDLE_D) begin errors++; $display("FAIL single_lat got %h want %h", bus.Data_o, IDLE_D); end
    tick();
    checks++; if (bus.Data_o !== 32'h0000_1234) begin errors++; $display("FAIL single_data got %h want 00001234", bus.Data_o); end
    checks++; if (bus.DecimalPoints_o !== 8'h42) begin errors++; $display("FAIL single_dp got %h want 42", bus.DecimalPoints_o); end
    dv[2] = 32'h0000_5678;
    tick();
    checks++; if (bus.Data_o !== 32'h0000_5678) begin errors++; $display("FAIL single_track got %h want 00005678", bus.Data_o); end
    tick(7);
    checks++; if (bus.Grant_o !== 4'b0100) begin errors++; $display("FAIL single_keep got %b want 0100", bus.Grant_o); end
    bus.Request_i = '0;
    tick();
    checks++; if (bus.Grant_o !== 4'b0) begin errors++; $display("FAIL single_drop got %b want 0000", bus.Grant_o); end
    checks++; if (bus.Busy_o !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", bus.Busy_o); end
    checks++; if (bus.Data_o !== IDLE_D) begin errors++; $display("FAIL single_blank got %h want %h", bus.Data_o, IDLE_D); end
    checks++; if (bus.DecimalPoints_o !== IDLE_P) begin errors++; $display("FAIL single_blank_dp got %h want %h", bus.DecimalPoints_o, IDLE_P); end
  endtask
  task automatic test_round_robin();
    logic [3:0] exp, prev;
    logic [31:0] ed;
    for (int n = 0; n < 4; n++) begin
      dv[n] = 32'(32'h1111_1111 * (n + 1));
      pv[n] = 8'(n + 1);
    end
    do_reset(4'b1111);
    prev = '0;
    for (int i = 0; i < 20; i++) begin
`ifdef DISPLAY_ARBITER_PRIORITY_EN
      exp = (i % 5 < 4) ? 4'b0001 : 4'b0010;
`else
      exp = 4'(1 << ((i / 4) % 4));
`endif
      tick();
      ed = IDLE_D;
      for (int n = 0; n < 4; n++) if (prev[n]) ed = dv[n];
      checks++; if (bus.Grant_o !== exp) begin errors++; $display("FAIL rr_grant cycle %0d got %b want %b", i, bus.Grant_o, exp); end
      checks++; if (bus.Data_o !== ed) begin errors++; $display("FAIL rr_data cycle %0d got %h want %h", i, bus.Data_o, ed); end
      prev = exp;
    end
  endtask
  task automatic test_linger();
    logic [31:0] frozen;
    do_reset(4'b0000);
    tick();
    bus.Request_i = 4'b0010;
    tick();
    checks++; if (bus.Grant_o !== 4'b0010) begin errors++; $display("FAIL linger_grant got %b want 0010", bus.Grant_o); end
    tick();
    checks++; if (bus.Data_o !== dv[1]) begin errors++; $display("FAIL linger_load got %h want %h", bus.Data_o, dv[1]); end
    frozen = dv[1];
    bus.Request_i = 4'b0000;
    tick();
    checks++; if (bus.Grant_o !== 4'b0) begin errors++; $display("FAIL linger_enter got %b want 0000", bus.Grant_o); end
    checks++; if (bus.Busy_o !== 1'b1) begin errors++; $display("FAIL linger_busy got %b want 1", bus.Busy_o); end
    dv[1] = 32'hDEAD_0001;
    bus.Request_i = 4'b1000;
    tick();
    checks++; if (bus.Grant_o !== 4'b0) begin errors++; $display("FAIL linger_wait got %b want 0000", bus.Grant_o); end
    checks++; if (bus.Data_o !== frozen) begin errors++; $display("FAIL linger_frozen got %h want %h", bus.Data_o, frozen); end
    tick();
    checks++; if (bus.Grant_o !== 4'b1000) begin errors++; $display("FAIL linger_regrant got %b want 1000", bus.Grant_o); end
    bus.Request_i = 4'b0000;
    tick(3);
    checks++; if (bus.Busy_o !== 1'b1) begin errors++; $display("FAIL linger2_busy got %b want 1", bus.Busy_o); end
    checks++; if (bus.Grant_o !== 4'b0) begin errors++; $display("FAIL linger2_grant got %b want 0000", bus.Grant_o); end
    tick();
    checks++; if (bus.Busy_o !== 1'b0) begin errors++; $display("FAIL linger2_idle got %b want 0", bus.Busy_o); end
    checks++; if (bus.Data_o !== IDLE_D) begin errors++; $display("FAIL linger2_blank got %h want %h", bus.Data_o, IDLE_D); end
  endtask
  task automatic test_drop_early();
    do_reset(4'b0011);
    tick(2);
    checks++; if (bus.Grant_o !== 4'b0001) begin errors++; $display("FAIL early_owner got %b want 0001", bus.Grant_o); end
    bus.Request_i = 4'b0010;
    tick();
    checks++; if (bus.Grant_o !== 4'b0) begin errors++; $display("FAIL early_linger got %b want 0000", bus.Grant_o); end
    checks++; if (bus.Busy_o !== 1'b1) begin errors++; $display("FAIL early_busy got %b want 1", bus.Busy_o); end
    tick();
    checks++; if (bus.Grant_o !== 4'b0) begin errors++; $display("FAIL early_wait got %b want 0000", bus.Grant_o); end
    tick();
    checks++; if (bus.Grant_o !== 4'b0010) begin errors++; $display("FAIL early_next got %b want 0010", bus.Grant_o); end
  endtask
  task automatic test_priority();
    logic [3:0] exp;
    do_reset(4'b0100);
    tick();
    checks++; if (bus.Grant_o !== 4'b0100) begin errors++; $display("FAIL prio_owner got %b want 0100", bus.Grant_o); end
    bus.Request_i = 4'b0101;
    for (int i = 2; i <= 5; i++) begin
      tick();
`ifdef DISPLAY_ARBITER_PRIORITY_EN
      exp = 4'b0001;
`else
      exp = i < 5 ? 4'b0100 : 4'b0001;
`endif
      checks++; if (bus.Grant_o !== exp) begin errors++; $display("FAIL prio_grant edge %0d got %b want %b", i, bus.Grant_o, exp); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.Grant_o !== 4'b0) begin errors++; $display("FAIL async_grant got %b want 0000", bus.Grant_o); end
    checks++; if (bus.Busy_o !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", bus.Busy_o); end
    checks++; if (bus.Data_o !== IDLE_D) begin errors++; $display("FAIL async_data got %h want %h", bus.Data_o, IDLE_D); end
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    bus.Request_i = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_linger();
    test_drop_early();
    test_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
